// File: rtl/ubr_seq.sv
// ubr_seq: clocked update-bit register with per-field address sequencers.
//
// Holds an update mask plus a base/stride/limit pointer for every operand field
// of a PIM instruction. On each accepted instruction, every enabled field
// advances its pointer by its stride. A field whose sum passes its limit returns
// to its base and pulses its wrap bit.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset
//   ubr_set      load the update mask from cw_mask
//   ubr_clr      clear the update mask (wins over ubr_set)
//   cw_mask      update-enable bits, bit i -> field i
//   base_ld      load base/stride/limit of field base_idx; pointer <= base_val
//   base_idx     field selected by base_ld (out-of-range index ignored)
//   base_val     base address
//   stride_val   stride (unsigned)
//   limit_val    last legal address (inclusive)
//   instr_valid  instruction issue request
//   instr_ready  registered accept; low for one cycle after any config write
//   ubr_en       current update mask
//   addr_out     current pointers, field i at [i*ADDR_W +: ADDR_W]
//   wrap         one-cycle pulse per field that wrapped
//   issue_cnt    accepted instructions since reset (mod 2^16)
module ubr_seq #(
  parameter int unsigned NUM_FIELDS = 5,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned STRIDE_W   = 4,
  parameter int unsigned IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ubr_set,
  input  logic                         ubr_clr,
  input  logic [NUM_FIELDS-1:0]        cw_mask,
  input  logic                         base_ld,
  input  logic [IDX_W-1:0]             base_idx,
  input  logic [ADDR_W-1:0]            base_val,
  input  logic [STRIDE_W-1:0]          stride_val,
  input  logic [ADDR_W-1:0]            limit_val,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  output logic [NUM_FIELDS-1:0]        ubr_en,
  output logic [NUM_FIELDS*ADDR_W-1:0] addr_out,
  output logic [NUM_FIELDS-1:0]        wrap,
  output logic [15:0]                  issue_cnt
);

  localparam int unsigned SumW = ADDR_W + 1;

  logic [NUM_FIELDS-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]     ptr_q    [NUM_FIELDS];
  logic [ADDR_W-1:0]     ptr_d    [NUM_FIELDS];
  logic [ADDR_W-1:0]     base_q   [NUM_FIELDS];
  logic [ADDR_W-1:0]     base_d   [NUM_FIELDS];
  logic [STRIDE_W-1:0]   stride_q [NUM_FIELDS];
  logic [STRIDE_W-1:0]   stride_d [NUM_FIELDS];
  logic [ADDR_W-1:0]     limit_q  [NUM_FIELDS];
  logic [ADDR_W-1:0]     limit_d  [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] wrap_q, wrap_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  logic                  fire;
  logic                  ld_ok;
  logic                  cfg_wr;
  logic [ADDR_W:0]       sum [NUM_FIELDS];

  assign fire   = instr_valid & ready_q;
  // Out-of-range indices are dropped entirely, including the settle slot.
  assign ld_ok  = base_ld && (32'(base_idx) < NUM_FIELDS);
  assign cfg_wr = ubr_set | ubr_clr | ld_ok;

  always_comb begin
    mask_d  = ubr_clr ? '0 : (ubr_set ? cw_mask : mask_q);
    cnt_d   = cnt_q + 16'(fire);
    ready_d = ~cfg_wr;
    wrap_d  = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      ptr_d[i]    = ptr_q[i];
      base_d[i]   = base_q[i];
      stride_d[i] = stride_q[i];
      limit_d[i]  = limit_q[i];
      // Sum is one bit wider so overflow past all-ones still compares as > limit.
      sum[i]      = SumW'(ptr_q[i]) + SumW'(stride_q[i]);
      if (ld_ok && (base_idx == IDX_W'(i))) begin
        // A load beats a concurrent advance on the same field.
        ptr_d[i]    = base_val;
        base_d[i]   = base_val;
        stride_d[i] = stride_val;
        limit_d[i]  = limit_val;
      end else if (fire && mask_q[i]) begin
        if (sum[i] > SumW'(limit_q[i])) begin
          ptr_d[i]  = base_q[i];
          wrap_d[i] = 1'b1;
        end else begin
          ptr_d[i]  = sum[i][ADDR_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      wrap_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        ptr_q[i]    <= '0;
        base_q[i]   <= '0;
        stride_q[i] <= '0;
        limit_q[i]  <= '1;
      end
    end else begin
      mask_q  <= mask_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        ptr_q[i]    <= ptr_d[i];
        base_q[i]   <= base_d[i];
        stride_q[i] <= stride_d[i];
        limit_q[i]  <= limit_d[i];
      end
    end
  end

  always_comb begin
    addr_out = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      addr_out[i*ADDR_W +: ADDR_W] = ptr_q[i];
    end
  end

  assign instr_ready = ready_q;
  assign ubr_en      = mask_q;
  assign wrap        = wrap_q;
  assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_ubr_seq.sv
// Scoreboard bench for ubr_seq: the driver pushes hand-computed expected
// outputs for the cycle after each edge; a negedge monitor pops and compares.
module tb_ubr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ubr_set, ubr_clr, base_ld, instr_valid;
  logic [4:0]  cw_mask;
  logic [2:0]  base_idx;
  logic [7:0]  base_val, limit_val;
  logic [3:0]  stride_val;
  logic        instr_ready;
  logic [4:0]  ubr_en, wrap;
  logic [39:0] addr_out;
  logic [15:0] issue_cnt;

  ubr_seq dut (
    .clk         (clk),
    .rst         (rst),
    .ubr_set     (ubr_set),
    .ubr_clr     (ubr_clr),
    .cw_mask     (cw_mask),
    .base_ld     (base_ld),
    .base_idx    (base_idx),
    .base_val    (base_val),
    .stride_val  (stride_val),
    .limit_val   (limit_val),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ubr_en      (ubr_en),
    .addr_out    (addr_out),
    .wrap        (wrap),
    .issue_cnt   (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic [39:0] addr;
    logic [4:0]  wrp;
    logic [4:0]  en;
    logic [15:0] cnt;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Hand-maintained expected state for the cycle after the next edge.
  logic [7:0]  e_ptr [5];
  logic [4:0]  e_wrap, e_en;
  logic [15:0] e_cnt;
  logic        e_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t m;
      m = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", m.nm, m.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".addr"}, addr_out, e.addr);
      chk({e.nm, ".wrap"}, 40'(wrap), 40'(e.wrp));
      chk({e.nm, ".en"}, 40'(ubr_en), 40'(e.en));
      chk({e.nm, ".cnt"}, 40'(issue_cnt), 40'(e.cnt));
      chk({e.nm, ".rdy"}, 40'(instr_ready), 40'(e.rdy));
    end
  end

  task automatic idle_in();
    rst = 1'b0; ubr_set = 1'b0; ubr_clr = 1'b0; cw_mask = '0;
    base_ld = 1'b0; base_idx = '0; base_val = '0; stride_val = '0;
    limit_val = '0; instr_valid = 1'b0;
  endtask

  // Push the expectation for the state after the coming edge, then clock it.
  task automatic step(input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.nm  = nm;
    for (int i = 0; i < 5; i++) e.addr[i*8 +: 8] = e_ptr[i];
    e.wrp = e_wrap; e.en = e_en; e.cnt = e_cnt; e.rdy = e_rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    idle_in();
    e_wrap = '0;
  endtask

  task automatic ld(input logic [2:0] idx, input logic [7:0] b, input logic [3:0] s,
                    input logic [7:0] l);
    base_ld = 1'b1; base_idx = idx; base_val = b; stride_val = s; limit_val = l;
  endtask

  initial begin
    idle_in();
    for (int i = 0; i < 5; i++) e_ptr[i] = 8'd0;
    e_wrap = '0; e_en = '0; e_cnt = '0; e_rdy = 1'b0;

    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      rst = 1'b1;
      {ubr_set, ubr_clr, base_ld, instr_valid} = 4'($urandom);
      cw_mask = 5'($urandom); base_idx = 3'($urandom); base_val = 8'($urandom);
      stride_val = 4'($urandom); limit_val = 8'($urandom);
      step("reset");
    end
    e_rdy = 1'b1;
    step("rdy_after_rst");

    // Basic advance on field 1: base 4, stride 2, limit 10.
    ld(3'd1, 8'd4, 4'd2, 8'd10); e_ptr[1] = 8'd4; e_rdy = 1'b0;
    step("ld_f1");
    ubr_set = 1'b1; cw_mask = 5'b00010; e_en = 5'b00010;
    step("set_f1");
    e_rdy = 1'b1;
    step("settle1");
    instr_valid = 1'b1; e_ptr[1] = 8'd6;  e_cnt = 16'd1; step("adv1");
    instr_valid = 1'b1; e_ptr[1] = 8'd8;  e_cnt = 16'd2; step("adv2");
    instr_valid = 1'b1; e_ptr[1] = 8'd10; e_cnt = 16'd3; step("adv3");
    instr_valid = 1'b1; e_ptr[1] = 8'd4;  e_cnt = 16'd4; e_wrap = 5'b00010;
    step("adv4_wrap");
    instr_valid = 1'b1; e_ptr[1] = 8'd6;  e_cnt = 16'd5; step("adv5");
    step("wrap_clears");

    // Mask timing: fire alongside ubr_set uses the old (cleared) mask.
    ubr_clr = 1'b1; e_en = 5'b00000; e_rdy = 1'b0; step("clr");
    e_rdy = 1'b1; step("settle2");
    ubr_set = 1'b1; cw_mask = 5'b11111; instr_valid = 1'b1;
    e_en = 5'b11111; e_cnt = 16'd6; e_rdy = 1'b0;
    step("fire_old_mask");
    instr_valid = 1'b1; e_rdy = 1'b1; step("no_fire_settle");
    instr_valid = 1'b1; e_ptr[1] = 8'd8; e_cnt = 16'd7; step("fire_new_mask");

    // Collision: load field 0 while firing; field 1 stride 1 at ptr 3.
    ld(3'd1, 8'd3, 4'd1, 8'd100); e_ptr[1] = 8'd3; e_rdy = 1'b0; step("ld_f1b");
    ubr_set = 1'b1; cw_mask = 5'b00011; e_en = 5'b00011; step("set_011");
    e_rdy = 1'b1; step("settle3");
    ld(3'd0, 8'd20, 4'd0, 8'd255); instr_valid = 1'b1;
    e_ptr[0] = 8'd20; e_ptr[1] = 8'd4; e_cnt = 16'd8; e_rdy = 1'b0;
    step("collision");

    // Edge arithmetic: 250 + 15 = 265 > 255 wraps to 250.
    ld(3'd2, 8'd250, 4'd15, 8'd255); e_ptr[2] = 8'd250; step("ld_f2");
    ubr_set = 1'b1; cw_mask = 5'b00100; e_en = 5'b00100; step("set_f2");
    e_rdy = 1'b1; step("settle4");
    instr_valid = 1'b1; e_cnt = 16'd9; e_wrap = 5'b00100; step("ovf_wrap");
    // Out-of-range index: ignored, no settle slot, fire proceeds.
    ld(3'd7, 8'd99, 4'd3, 8'd1); instr_valid = 1'b1;
    e_cnt = 16'd10; e_wrap = 5'b00100; step("bad_idx");
    instr_valid = 1'b1; e_cnt = 16'd11; e_wrap = 5'b00100; step("ovf_wrap2");

    // base > limit: every enabled fire wraps back to base.
    ld(3'd3, 8'd50, 4'd1, 8'd40); e_ptr[3] = 8'd50; e_rdy = 1'b0; step("ld_f3");
    ubr_set = 1'b1; cw_mask = 5'b01000; e_en = 5'b01000; step("set_f3");
    e_rdy = 1'b1; step("settle5");
    instr_valid = 1'b1; e_cnt = 16'd12; e_wrap = 5'b01000; step("base_gt_limit");

    // All fields enabled, then reset mid-operation.
    ubr_set = 1'b1; cw_mask = 5'b11111; e_en = 5'b11111; e_rdy = 1'b0; step("set_all");
    e_rdy = 1'b1; step("settle6");
    instr_valid = 1'b1; e_ptr[1] = 8'd5; e_cnt = 16'd13; e_wrap = 5'b01100;
    step("fire_all");
    rst = 1'b1; instr_valid = 1'b1; ubr_set = 1'b1; cw_mask = 5'b11111;
    for (int i = 0; i < 5; i++) e_ptr[i] = 8'd0;
    e_en = '0; e_cnt = '0; e_rdy = 1'b0;
    step("midop_rst");
    instr_valid = 1'b1; e_rdy = 1'b1; step("post_rst");
    instr_valid = 1'b1; e_cnt = 16'd1; step("post_rst_fire");

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
